// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter dump sequencer.
// PERF_DUMP_CHECKSUM_EN appends an XOR checksum word after the five counters.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } perf_state_e;

`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int NUM_PERF_WORDS = 6;
`else
  localparam int NUM_PERF_WORDS = 5;
`endif

  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] IDX_CYCLES = 3'd0;
  localparam logic [IDX_W-1:0] IDX_INSTR  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_ARITH  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_MEM    = 3'd3;
  localparam logic [IDX_W-1:0] IDX_STALL  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_CSUM   = 3'd5;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_PERF_WORDS - 1);

endpackage

// File: rtl/perf_snapshot_regs.sv
// Snapshot bank for the five counters plus the word-index read mux.
// PERF_DUMP_CHECKSUM_EN adds the XOR checksum as word index 5.
module perf_snapshot_regs
  import perf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [31:0]      cycles_i,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      arith_i,
  input  logic [31:0]      mem_i,
  input  logic [31:0]      stall_i,
  output logic [31:0]      word_o
);

  logic [31:0] cycles_q;
  logic [31:0] instr_q;
  logic [31:0] arith_q;
  logic [31:0] mem_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q <= '0;
      instr_q  <= '0;
      arith_q  <= '0;
      mem_q    <= '0;
      stall_q  <= '0;
    end else if (capture_i) begin
      cycles_q <= cycles_i;
      instr_q  <= instr_i;
      arith_q  <= arith_i;
      mem_q    <= mem_i;
      stall_q  <= stall_i;
    end
  end

  always_comb begin
    word_o = '0;
    case (index_i)
      IDX_CYCLES: word_o = cycles_q;
      IDX_INSTR:  word_o = instr_q;
      IDX_ARITH:  word_o = arith_q;
      IDX_MEM:    word_o = mem_q;
      IDX_STALL:  word_o = stall_q;
`ifdef PERF_DUMP_CHECKSUM_EN
      IDX_CSUM:   word_o = cycles_q ^ instr_q ^ arith_q ^ mem_q ^ stall_q;
`endif
      default:    word_o = '0;
    endcase
  end

endmodule

// File: rtl/perf_counter_dump_ctrl.sv
// Snapshots the perf counters on finish rise or host request and streams them to memory.
// PERF_DUMP_CHECKSUM_EN (see perf_pkg) extends the dump with an XOR checksum word.
module perf_counter_dump_ctrl
  import perf_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(32'h0000_0400)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              finish,
  input  logic              dump_req,
  input  logic [31:0]       cycles,
  input  logic [31:0]       instr_count,
  input  logic [31:0]       aritmetric_count,
  input  logic [31:0]       memory_count,
  input  logic [31:0]       stall_count,
  input  logic              mem_wr_ready,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              freeze,
  output logic              busy,
  output logic              done
);

  // Handshake: a word transfers in the first cycle where mem_wr_valid and
  // mem_wr_ready are both high; addr/data never change while valid & ~ready.

  perf_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic             finish_q;
  logic             trig;

  assign trig = (finish & ~finish_q) | dump_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= finish;
      case (state_q)
        IDLE: begin
          if (trig) state_q <= SNAP;
        end
        SNAP: begin
          idx_q   <= '0;
          state_q <= WRITE;
        end
        WRITE: begin
          if (mem_wr_ready) begin
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          // Holding here while finish stays high prevents a retrigger.
          if (!finish && !dump_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  perf_snapshot_regs u_snap (
    .clk       (clk),
    .rst       (rst),
    .capture_i (state_q == SNAP),
    .index_i   (idx_q),
    .cycles_i  (cycles),
    .instr_i   (instr_count),
    .arith_i   (aritmetric_count),
    .mem_i     (memory_count),
    .stall_i   (stall_count),
    .word_o    (mem_wr_data)
  );

  assign mem_wr_addr  = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
  assign mem_wr_valid = (state_q == WRITE);
  assign freeze       = (state_q == SNAP) || (state_q == WRITE);
  assign busy         = (state_q == SNAP) || (state_q == WRITE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_perf_counter_dump_ctrl.sv
// Directed bench for perf_counter_dump_ctrl with a queue-based write scoreboard.
// Build with +define+PERF_DUMP_CHECKSUM_EN to cover the checksum word.
module tb_perf_counter_dump_ctrl;
  import perf_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef PERF_DUMP_CHECKSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        finish, dump_req, mem_wr_ready;
  logic [31:0] cycles, instr_count, aritmetric_count, memory_count, stall_count;
  logic        mem_wr_valid, freeze, busy, done;
  logic [31:0] mem_wr_addr, mem_wr_data;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [63:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  perf_counter_dump_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .finish           (finish),
    .dump_req         (dump_req),
    .cycles           (cycles),
    .instr_count      (instr_count),
    .aritmetric_count (aritmetric_count),
    .memory_count     (memory_count),
    .stall_count      (stall_count),
    .mem_wr_ready     (mem_wr_ready),
    .mem_wr_valid     (mem_wr_valid),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .freeze           (freeze),
    .busy             (busy),
    .done             (done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops one expectation per accepted word
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_addr", {32'h0, mem_wr_addr}, {32'h0, prev_addr});
        check("hold_data", {32'h0, mem_wr_data}, {32'h0, prev_data});
      end
      if (mem_wr_valid && mem_wr_ready) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h want no write", mem_wr_addr, mem_wr_data);
        end else begin
          check("write", {mem_wr_addr, mem_wr_data}, exp_q.pop_front());
        end
      end
      prev_stall = mem_wr_valid && !mem_wr_ready;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
    end
  end

  // driver tasks
  task automatic set_counters(input logic [31:0] c, i, a, m, s);
    cycles = c; instr_count = i; aritmetric_count = a; memory_count = m; stall_count = s;
  endtask

  task automatic push_dump(input logic [31:0] c, i, a, m, s, input int nwords);
    logic [31:0] w [0:5];
    w[0] = c; w[1] = i; w[2] = a; w[3] = m; w[4] = s; w[5] = c ^ i ^ a ^ m ^ s;
    for (int k = 0; k < nwords; k++) exp_q.push_back({BASE + 32'(4 * k), w[k]});
  endtask

  // Counts posedges from the trigger until done is seen; clears dump_req after one cycle.
  task automatic wait_done(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) dump_req = 1'b0;
      if (done) begin
        n = k;
        if (busy || freeze) busy_ok = 1'b0;
        return;
      end
      if (!busy || !freeze) busy_ok = 1'b0;
    end
    n = -1;
  endtask

  int   n, base_cnt;
  logic bok;

  initial begin
    rst = 1'b1; finish = 1'b0; dump_req = 1'b0; mem_wr_ready = 1'b1;
    set_counters(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  {63'h0, mem_wr_valid}, 64'h0);
    check("rst_busy",   {63'h0, busy},         64'h0);
    check("rst_done",   {63'h0, done},         64'h0);
    check("rst_freeze", {63'h0, freeze},       64'h0);
    check("rst_addr",   {32'h0, mem_wr_addr},  {32'h0, BASE});
    check("rst_data",   {32'h0, mem_wr_data},  64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // finish rise, ready held high
    set_counters(100, 40, 25, 10, 5);
    push_dump(100, 40, 25, 10, 5, NW);
    finish = 1'b1;
    wait_done(n, bok);
    check("t1_latency", 64'(n), 64'(NW + 2));
    check("t1_freeze",  {63'h0, bok}, 64'h1);
    check("t1_drain",   64'(exp_q.size()), 64'h0);

    // finish still high in DONE: no retrigger
    base_cnt = wr_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("hold_done",    {63'h0, done}, 64'h1);
    check("hold_nowrite", 64'(wr_cnt - base_cnt), 64'h0);
    finish = 1'b0;
    @(posedge clk); #1;
    check("idle_done", {63'h0, done}, 64'h0);
    check("idle_busy", {63'h0, busy}, 64'h0);

    // host request starts a fresh dump
    set_counters(32'h7, 32'h8, 32'h9, 32'hA, 32'hFFFF_FFFF);
    push_dump(32'h7, 32'h8, 32'h9, 32'hA, 32'hFFFF_FFFF, NW);
    dump_req = 1'b1;
    wait_done(n, bok);
    check("t5_latency", 64'(n), 64'(NW + 2));
    @(posedge clk); #1;

    // backpressure: ready low 3 cycles while word 2 is presented
    set_counters(100, 40, 25, 10, 5);
    push_dump(100, 40, 25, 10, 5, NW);
    dump_req = 1'b1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 mem_wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_wr_ready = 1'b1;
      end
      wait_done(n, bok);
    join
    check("t2_latency", 64'(n), 64'(NW + 5));
    check("t2_freeze",  {63'h0, bok}, 64'h1);
    @(posedge clk); #1;

    // counters move after the snapshot
    set_counters(100, 40, 25, 10, 5);
    push_dump(100, 40, 25, 10, 5, NW);
    dump_req = 1'b1;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 cycles = 999;
      end
      wait_done(n, bok);
    join
    check("t3_latency", 64'(n), 64'(NW + 2));
    @(posedge clk); #1;

    // dump_req during WRITE is dropped
    set_counters(1, 2, 3, 4, 5);
    push_dump(1, 2, 3, 4, 5, NW);
    base_cnt = wr_cnt;
    dump_req = 1'b1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
      end
      wait_done(n, bok);
    join
    repeat (4) @(posedge clk);
    #1;
    check("t4_count", 64'(wr_cnt - base_cnt), 64'(NW));
    check("t4_idle",  {63'h0, busy}, 64'h0);

    // reset after word 1 accepted
    set_counters(11, 22, 33, 44, 55);
    push_dump(11, 22, 33, 44, 55, 2);
    base_cnt = wr_cnt;
    dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_valid",  {63'h0, mem_wr_valid}, 64'h0);
    check("t6_busy",   {63'h0, busy},         64'h0);
    check("t6_freeze", {63'h0, freeze},       64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_count", 64'(wr_cnt - base_cnt), 64'h2);
    check("t6_drain", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_dump_ctrl.md
Name: perf_counter_dump_ctrl

Overview:
Sequencer that snapshots the five processor performance counters (cycles, instr_count, aritmetric_count, memory_count, stall_count) and writes them as consecutive 32-bit words to data memory over a valid/ready write port.
- Triggered by program completion (finish rising edge) or by an explicit host dump request.
- Sits between the special register manager and the data-memory write arbiter.
- Drives a freeze line that holds the counters stable while a dump is in flight.

Parameters:
- BASE_ADDR, 32'h0000_0400: byte address of the first dumped word; must be 4-byte aligned.
- ADDR_W, 32: width of mem_wr_addr.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- finish  input  1  program-complete level from the core.
- dump_req  input  1  single-cycle host request for a dump.
- cycles  input  32  counter value.
- instr_count  input  32  counter value.
- aritmetric_count  input  32  counter value.
- memory_count  input  32  counter value.
- stall_count  input  32  counter value.
- mem_wr_ready  input  1  memory accepts the current word.
- mem_wr_valid  output  1  a word is presented.
- mem_wr_addr  output  ADDR_W  byte address of the presented word.
- mem_wr_data  output  32  presented word.
- freeze  output  1  counter-hold request to the counter block.
- busy  output  1  dump in progress.
- done  output  1  dump complete.

Behaviour:
- Reset (async, immediate): state=IDLE; word index=0; snapshot regs=0; finish_q=0.
  - All outputs 0, mem_wr_addr=BASE_ADDR.
  - Reset mid-dump drops mem_wr_valid in the same instant, with no completion of the in-flight word.
- Trigger: trig = (finish & ~finish_q) | dump_req.
  - Sampled only in IDLE; ignored in any other state, with no queuing.
  - finish_q is registered every cycle.
- FSM states:
  - IDLE: busy=0, freeze=0. On trig, go to SNAP.
  - SNAP: one cycle; freeze=1, busy=1. At the end of the cycle, capture all five inputs into snapshot regs and set index=0. Go to WRITE.
  - WRITE: mem_wr_valid=1; freeze=1; busy=1.
    - mem_wr_addr = BASE_ADDR + 4*index; mem_wr_data = snapshot[index].
    - Addr and data stay stable while valid & ~ready.
    - On valid & ready, index increments.
    - On acceptance of the last word, go to DONE with valid deasserted the next cycle.
  - DONE: done=1, busy=0, freeze=0, valid=0.
    - Return to IDLE when finish=0 and dump_req=0. Otherwise hold in DONE, so a sustained finish does not retrigger.
- Word order (index 0..4): cycles, instr_count, aritmetric_count, memory_count, stall_count.
- Ready may be high before or with valid; the transfer occurs in the first cycle where both are high. Back-to-back acceptance gives one word per cycle.
- Latency with ready held high: trig at cycle T, SNAP at T+1, words at T+2..T+6, done at T+7.
- Address arithmetic is ADDR_W-bit with wrap-around; no overflow detection.

Optional Feature:
- Macro PERF_DUMP_CHECKSUM_EN.
- When defined:
  - A sixth word (index 5) is written at BASE_ADDR+20.
  - Its value is the XOR of the five snapshot words.
  - With ready held high, done asserts at T+8.
- When undefined: exactly five words are written and no checksum logic exists.

Decomposition:
- Shared package perf_pkg holds:
  - the FSM state enum (IDLE, SNAP, WRITE, DONE);
  - NUM_PERF_WORDS (5, or 6 with the macro);
  - word-index localparams: IDX_CYCLES=0, IDX_INSTR=1, IDX_ARITH=2, IDX_MEM=3, IDX_STALL=4, IDX_CSUM=5.
- One natural sub-module, perf_snapshot_regs: the snapshot register bank plus index mux, with inputs capture/index and output the selected word.

Test Plan:
- Reset, then finish 0→1 with cycles=100, instr=40, arith=25, mem=10, stall=5, ready=1:
  - addrs 0x400..0x410 carry data 100, 40, 25, 10, 5;
  - done at T+7; freeze high T+1..T+6.
- Backpressure: ready low for 3 cycles on word 2 (arith=25):
  - addr 0x408 and data 25 held stable for all 3 cycles;
  - done delayed by exactly 3 cycles.
- Inputs change after SNAP (cycles jumps to 999) → dumped cycles word is still 100.
- dump_req pulse during WRITE → ignored; exactly 5 writes.
- Trigger/return interaction:
  - finish held high in DONE → no retrigger;
  - finish low → IDLE;
  - dump_req → new dump.
- rst asserted mid-dump after word 1 → valid=0, busy=0 immediately; no further writes.
- With PERF_DUMP_CHECKSUM_EN, the inputs above → sixth word at 0x414 = 100^40^25^10^5.
